// File: rtl/fma_spec_handler_pipe.sv
// Multi-lane FMA special-case handler: classifies a*b+/-c operands per lane and
// resolves NaN/invalid/overflow/underflow/zero/inf results through a two-stage valid/ready pipe.
module fma_spec_handler_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LANES = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              nj_mode,
  input  logic                              sub_mode,
  input  logic [LANES-1:0]                  lane_en,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0]  op_a,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0]  op_b,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0]  op_c,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES-1:0]                  spec_mask,
  output logic [LANES*(1+EXP_W+MAN_W)-1:0]  res_spec,
  output logic [4:0]                        flags,
  input  logic                              flag_clr
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [EXP_W+1:0] BIAS2_V = (EXP_W+2)'(2 * BIAS);
  localparam logic [EXP_W+1:0] OVF_LIM = (EXP_W+2)'(BIAS);
  localparam logic [EXP_W+1:0] UNF_LIM = (EXP_W+2)'(1 - BIAS);
  localparam logic [W-2:0]     INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic a_zero;
    logic a_inf;
    logic a_nan;
    logic b_zero;
    logic b_inf;
    logic b_nan;
    logic c_inf;
    logic c_nan;
    logic ovf;
    logic unf;
    logic sign_ab;
  } lane_cls_t;

  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = !rst && s1_adv;

  // ---------------- stage 1: classification ----------------
  lane_cls_t [LANES-1:0] cls_d, cls_q;
  logic [LANES*W-1:0]    a_q, b_q, c_q;
  logic [LANES-1:0]      en_q;
  logic                  nj_q, sub_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_s1
    logic [EXP_W-1:0] ea, eb, ec;
    logic [MAN_W-1:0] ma, mb, mc;
    logic [EXP_W+1:0] e_ab;
    lane_cls_t        cls_l;

    assign ea   = op_a[gi*W+MAN_W +: EXP_W];
    assign eb   = op_b[gi*W+MAN_W +: EXP_W];
    assign ec   = op_c[gi*W+MAN_W +: EXP_W];
    assign ma   = op_a[gi*W +: MAN_W];
    assign mb   = op_b[gi*W +: MAN_W];
    assign mc   = op_c[gi*W +: MAN_W];
    // Unbiased product exponent; wraps into a signed EXP_W+2 field.
    assign e_ab = {2'b00, ea} + {2'b00, eb} - BIAS2_V;

    always_comb begin
      cls_l         = '0;
      cls_l.a_zero  = (ea == '0) && (ma == '0);
      cls_l.a_inf   = (&ea) && (ma == '0);
      cls_l.a_nan   = (&ea) && (ma != '0);
      cls_l.b_zero  = (eb == '0) && (mb == '0);
      cls_l.b_inf   = (&eb) && (mb == '0);
      cls_l.b_nan   = (&eb) && (mb != '0);
      cls_l.c_inf   = (&ec) && (mc == '0);
      cls_l.c_nan   = (&ec) && (mc != '0);
      cls_l.ovf     = $signed(e_ab) > $signed(OVF_LIM);
      cls_l.unf     = $signed(e_ab) < $signed(UNF_LIM);
      cls_l.sign_ab = op_a[gi*W+W-1] ^ op_b[gi*W+W-1];
    end

    assign cls_d[gi] = cls_l;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      cls_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      en_q       <= '0;
      nj_q       <= 1'b0;
      sub_q      <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      cls_q      <= cls_d;
      a_q        <= op_a;
      b_q        <= op_b;
      c_q        <= op_c;
      en_q       <= lane_en;
      nj_q       <= nj_mode;
      sub_q      <= sub_mode;
    end
  end

  // ---------------- stage 2: priority resolution ----------------
  logic [LANES-1:0]   mask_d, mask_q;
  logic [LANES*W-1:0] res_d, res_q;
  logic [LANES*5-1:0] hit_lanes;
  logic [4:0]         hits_d, hits_q;
  logic [4:0]         flags_d, flags_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_s2
    lane_cls_t  cl;
    logic [W-1:0] a_l, b_l, c_l, ce_l, inf_ab, res_l;
    logic         mask_l;
    logic [4:0]   hit_l;

    assign cl     = cls_q[gi];
    assign a_l    = a_q[gi*W +: W];
    assign b_l    = b_q[gi*W +: W];
    assign c_l    = c_q[gi*W +: W];
    assign ce_l   = {c_l[W-1] ^ sub_q, c_l[W-2:0]};
    assign inf_ab = {cl.sign_ab, INF_MAG};

    // hit_l bits: {nan, invalid, overflow, underflow, inf}; the zero case raises no flag.
    always_comb begin
      res_l  = '0;
      mask_l = 1'b0;
      hit_l  = '0;
      if (en_q[gi]) begin
        mask_l = 1'b1;
        if (cl.a_nan || cl.b_nan || cl.c_nan) begin
          hit_l[4] = 1'b1;
          res_l    = cl.a_nan ? a_l : (cl.b_nan ? b_l : c_l);
        end else if ((cl.a_inf && cl.b_zero) || (cl.a_zero && cl.b_inf) ||
                     ((cl.a_inf || cl.b_inf) && cl.c_inf && (cl.sign_ab != ce_l[W-1]))) begin
          hit_l[3] = 1'b1;
          res_l    = QNAN;
        end else if (cl.ovf && !cl.a_zero && !cl.b_zero) begin
          hit_l[2] = 1'b1;
          res_l    = inf_ab;
        end else if (nj_q && cl.unf && !(cl.a_inf || cl.b_inf || cl.c_inf)) begin
          hit_l[1] = 1'b1;
          res_l    = ce_l;
        end else if (cl.a_zero || cl.b_zero) begin
          res_l    = ce_l;
        end else if (cl.a_inf || cl.b_inf) begin
          hit_l[0] = 1'b1;
          res_l    = inf_ab;
        end else if (cl.c_inf) begin
          hit_l[0] = 1'b1;
          res_l    = ce_l;
        end else begin
          mask_l   = 1'b0;
        end
      end
    end

    assign res_d[gi*W +: W]     = res_l;
    assign mask_d[gi]           = mask_l;
    assign hit_lanes[gi*5 +: 5] = hit_l;
  end

  always_comb begin
    hits_d = '0;
    for (int i = 0; i < LANES; i++) begin
      hits_d = hits_d | hit_lanes[i*5 +: 5];
    end
  end

  // A set arriving with flag_clr wins over the clear.
  always_comb begin
    flags_d = flag_clr ? 5'b0 : flags_q;
    if (s2_valid_q && out_ready) begin
      flags_d = flags_d | hits_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      mask_q     <= '0;
      res_q      <= '0;
      hits_q     <= '0;
      flags_q    <= '0;
    end else begin
      flags_q <= flags_d;
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        mask_q     <= mask_d;
        res_q      <= res_d;
        hits_q     <= hits_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign spec_mask = mask_q;
  assign res_spec  = res_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fma_spec_handler_pipe.sv
// Bench for fma_spec_handler_pipe: directed special cases plus randomized traffic
// scored against an IEEE-rule reference model and a sticky-flag model.
module tb_fma_spec_handler_pipe;

  localparam int LANES = 4;
  localparam int W     = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               nj_mode = 1'b0;
  logic               sub_mode = 1'b0;
  logic [LANES-1:0]   lane_en = '0;
  logic [LANES*W-1:0] op_a = '0, op_b = '0, op_c = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [LANES-1:0]   spec_mask;
  logic [LANES*W-1:0] res_spec;
  logic [4:0]         flags;
  logic               flag_clr = 1'b0;

  // half-precision, two-lane build
  logic        h_in_valid = 1'b0;
  logic        h_in_ready;
  logic [1:0]  h_lane_en = '0;
  logic [31:0] h_op_a = '0, h_op_b = '0, h_op_c = '0;
  logic        h_out_valid;
  logic [1:0]  h_mask;
  logic [31:0] h_res;
  logic [4:0]  h_flags;

  always #5 clk = ~clk;

  fma_spec_handler_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .nj_mode(nj_mode), .sub_mode(sub_mode), .lane_en(lane_en),
    .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .spec_mask(spec_mask), .res_spec(res_spec), .flags(flags), .flag_clr(flag_clr)
  );

  fma_spec_handler_pipe #(.EXP_W(5), .MAN_W(10), .LANES(2)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .nj_mode(1'b0), .sub_mode(1'b0), .lane_en(h_lane_en),
    .op_a(h_op_a), .op_b(h_op_b), .op_c(h_op_c),
    .out_valid(h_out_valid), .out_ready(1'b1),
    .spec_mask(h_mask), .res_spec(h_res), .flags(h_flags), .flag_clr(1'b0)
  );

  typedef struct {
    logic [LANES-1:0]   mask;
    logic [LANES*W-1:0] res;
    logic [4:0]         hits;
  } exp_t;

  exp_t               exp_q[$];
  logic [4:0]         model_flags = '0;
  bit                 stall_pend = 0;
  logic [LANES-1:0]   held_mask;
  logic [LANES*W-1:0] held_res;
  int                 n_checks = 0;
  int                 n_errors = 0;
  int                 lat;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference for one lane: returns {hits[4:0], mask, result[31:0]}.
  function automatic logic [37:0] ref_lane(input logic [31:0] a, b, c, input bit nj, sub, en);
    int ea = int'(a[30:23]);
    int eb = int'(b[30:23]);
    int ec = int'(c[30:23]);
    bit az = (ea == 0) && (a[22:0] == 0);
    bit ai = (ea == 255) && (a[22:0] == 0);
    bit an = (ea == 255) && (a[22:0] != 0);
    bit bz = (eb == 0) && (b[22:0] == 0);
    bit bi = (eb == 255) && (b[22:0] == 0);
    bit bn = (eb == 255) && (b[22:0] != 0);
    bit ci = (ec == 255) && (c[22:0] == 0);
    bit cn = (ec == 255) && (c[22:0] != 0);
    int e_ab = ea + eb - 254;
    bit sab = a[31] ^ b[31];
    logic [31:0] ce = {c[31] ^ sub, c[30:0]};
    logic [31:0] inf_ab = {sab, 8'hFF, 23'h0};
    if (!en) return '0;
    if (an || bn || cn) return {5'b10000, 1'b1, an ? a : (bn ? b : c)};
    if ((ai && bz) || (az && bi) || ((ai || bi) && ci && (sab != ce[31])))
      return {5'b01000, 1'b1, 32'h7FC00000};
    if (e_ab > 127 && !az && !bz) return {5'b00100, 1'b1, inf_ab};
    if (nj && e_ab < -126 && !(ai || bi || ci)) return {5'b00010, 1'b1, ce};
    if (az || bz) return {5'b00000, 1'b1, ce};
    if (ai || bi) return {5'b00001, 1'b1, inf_ab};
    if (ci) return {5'b00001, 1'b1, ce};
    return '0;
  endfunction

  function automatic exp_t model_beat();
    exp_t e;
    logic [37:0] r;
    e.mask = '0;
    e.res  = '0;
    e.hits = '0;
    for (int i = 0; i < LANES; i++) begin
      r = ref_lane(op_a[i*W +: W], op_b[i*W +: W], op_c[i*W +: W], nj_mode, sub_mode, lane_en[i]);
      e.res[i*W +: W] = r[31:0];
      e.mask[i]       = r[32];
      e.hits          = e.hits | r[37:33];
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 7))
      0:       return {r[31], 31'h0};
      1:       return {r[31], 8'hFF, 23'h0};
      2:       return {r[31], 8'hFF, r[22:1], 1'b1};
      3:       return {r[31], r[30:23] | 8'hC0, r[22:0]};
      4:       return {r[31], r[30:23] & 8'h1F, r[22:0]};
      default: return r;
    endcase
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < LANES; i++) begin
      op_a[i*W +: W] = rand_op();
      op_b[i*W +: W] = rand_op();
      op_c[i*W +: W] = rand_op();
    end
    nj_mode  = 1'(($urandom) & 1);
    sub_mode = 1'(($urandom) & 1);
    lane_en  = LANES'($urandom);
  endtask

  // Sample just after the falling edge, score handshakes due at the next rising edge.
  task automatic tick();
    exp_t e;
    bit in_hs, out_hs;
    #1;
    in_hs  = in_valid && in_ready;
    out_hs = out_valid && out_ready;
    if (rst) begin
      exp_q.delete();
      model_flags = '0;
      stall_pend  = 0;
    end else begin
      check_val("flags", flags, model_flags);
      if (stall_pend) begin
        check_val("stall_valid", out_valid, 1'b1);
        check_val("stall_mask", spec_mask, held_mask);
        check_val("stall_res", res_spec, held_res);
      end
      if (flag_clr) model_flags = '0;
      if (out_hs) begin
        check_val("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_val("sb_mask", spec_mask, e.mask);
          check_val("sb_res", res_spec, e.res);
          model_flags = model_flags | e.hits;
        end
      end
      stall_pend = out_valid && !out_ready;
      held_mask  = spec_mask;
      held_res   = res_spec;
      if (in_hs) exp_q.push_back(model_beat());
    end
    @(negedge clk);
  endtask

  task automatic run_dir(input string tag, input logic [31:0] a, b, c, input bit nj, sub, en0,
                         input logic [31:0] exp_res, input bit exp_mask, input logic [4:0] exp_flags);
    op_a = '0; op_b = '0; op_c = '0;
    op_a[31:0] = a; op_b[31:0] = b; op_c[31:0] = c;
    nj_mode = nj; sub_mode = sub; lane_en = {3'b000, en0};
    in_valid = 1'b1; out_ready = 1'b1; flag_clr = 1'b1;
    tick();
    in_valid = 1'b0; flag_clr = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    check_val({tag, "_lat"}, lat, 2);
    check_val({tag, "_mask"}, spec_mask[0], exp_mask);
    check_val({tag, "_res"}, res_spec[31:0], exp_res);
    tick();
    check_val({tag, "_flags"}, flags, exp_flags);
    $display("dir %s: a=%h b=%h c=%h res=%h mask=%b flags=%b", tag, a, b, c, res_spec[31:0], spec_mask[0], flags);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
    while ((exp_q.size() > 0 || out_valid) && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", in_ready, 1'b0);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_mask", spec_mask, '0);
    check_val("rst_res", res_spec, '0);
    check_val("rst_flags", flags, '0);
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    run_dir("invalid_infsub", 32'h3F800000, 32'h7F800000, 32'h7F800000, 0, 1, 1, 32'h7FC00000, 1, 5'b01000);
    run_dir("nan_a_wins",     32'h7FC00001, 32'h7F800001, 32'h7FC00000, 0, 0, 1, 32'h7FC00001, 1, 5'b10000);
    run_dir("lane_disabled",  32'h7FC00001, 32'h7F800001, 32'h7FC00000, 0, 0, 0, 32'h00000000, 0, 5'b00000);
    run_dir("overflow",       32'h7F000000, 32'h7F000000, 32'h3F800000, 0, 0, 1, 32'h7F800000, 1, 5'b00100);
    run_dir("underflow_nj",   32'h00800000, 32'h00800000, 32'h40000000, 1, 0, 1, 32'h40000000, 1, 5'b00010);
    run_dir("underflow_java", 32'h00800000, 32'h00800000, 32'h40000000, 0, 0, 1, 32'h00000000, 0, 5'b00000);
    run_dir("zero_sub",       32'h00000000, 32'hBF800000, 32'h3F800000, 0, 1, 1, 32'hBF800000, 1, 5'b00000);
    run_dir("inf_product",    32'hFF800000, 32'h3E800000, 32'h00000000, 0, 0, 1, 32'hFF800000, 1, 5'b00001);
    run_dir("inf_c",          32'h3F800000, 32'h3F800000, 32'h7F800000, 0, 1, 1, 32'hFF800000, 1, 5'b00001);

    // Eight beats with out_ready toggling every cycle.
    sent = 0; cyc = 0;
    while (sent < 8 && cyc < 100) begin
      rand_inputs();
      in_valid  = 1'b1;
      out_ready = (cyc % 2 == 0);
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    check_val("stream_sent", sent, 8);
    drain("stream");
    $display("stream: 8 beats with toggling out_ready in %0d cycles", cyc);

    // Clear coinciding with a fresh overflow: the set must win.
    op_a = '0; op_b = '0; op_c = '0;
    op_a[31:0] = 32'h7F000000; op_b[31:0] = 32'h7F000000; op_c[31:0] = 32'h3F800000;
    lane_en = 4'b0001; nj_mode = 1'b0; sub_mode = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check_val("clr_vs_set_ovf", flags, 5'b00100);
    $display("clr+set: flags=%b", flags);

    // Randomized traffic with backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flag_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end
    drain("random");
    $display("random: 400 cycles scored, flags=%b", flags);

    // Fill both stages under stall, then reset.
    run_dir("pre_rst_invalid", 32'h3F800000, 32'h7F800000, 32'h7F800000, 0, 1, 1, 32'h7FC00000, 1, 5'b01000);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      in_valid = 1'b1;
      tick();
    end
    check_val("full_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    check_val("midrst_out_valid", out_valid, 1'b0);
    check_val("midrst_flags", flags, '0);
    check_val("midrst_mask", spec_mask, '0);
    check_val("midrst_res", res_spec, '0);
    check_val("midrst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check_val("midrst_in_ready_after", in_ready, 1'b1);
    @(negedge clk);
    tick();
    check_val("midrst_no_ghost", out_valid, 1'b0);
    $display("reset mid-transfer: out_valid=%b flags=%b", out_valid, flags);

    // Half-precision build: inf * 0 -> canonical QNaN.
    h_op_a = 32'h00007C00; h_op_b = '0; h_op_c = '0;
    h_lane_en = 2'b01; h_in_valid = 1'b1;
    tick();
    h_in_valid = 1'b0;
    lat = 1;
    while (!h_out_valid && lat < 8) begin
      tick();
      lat++;
    end
    check_val("half_lat", lat, 2);
    check_val("half_mask", h_mask, 2'b01);
    check_val("half_res", h_res, 32'h00007E00);
    $display("half: res=%h mask=%b", h_res, h_mask);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fma_spec_handler_pipe.md
# fma_spec_handler_pipe

Pipelined, multi-lane special-case handler for the vector FMA datapath; successor to the single-lane combinational first-stage handler. Each lane classifies operands a, b, c of a*b±c and resolves NaN, invalid, overflow, underflow, zero and infinity cases, emitting a bypass mask and the final special result. It sits in parallel with the multiplier front end, adds a two-stage valid/ready pipeline, exponent/mantissa widths and lane count as parameters, a subtract mode, and sticky exception flags.

## Interface
- EXP_W, 8, exponent width
- MAN_W, 23, mantissa width; word width W = 1+EXP_W+MAN_W
- LANES, 4, independent lanes
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- nj_mode  in  1  1: underflow flushes product (non-Java); 0: underflow treated as normal
- sub_mode  in  1  1: a*b - c; 0: a*b + c
- lane_en  in  LANES  per-lane enable; disabled lanes output mask 0, result 0, raise no flags
- op_a, op_b, op_c  in  LANES*W each  operands, lane i in bits [i*W +: W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- spec_mask  out  LANES  lane result is special, main datapath bypassed
- res_spec  out  LANES*W  special result per lane, 0 where mask is 0
- flags  out  5  sticky {nan, invalid, overflow, underflow, inf}
- flag_clr  in  1  clear sticky flags

## Operation
- Classify per operand: zero (exp=0, man=0), inf (exp all-1, man=0), NaN (exp all-1, man≠0). Denormal inputs (exp=0, man≠0) are not special.
- Product exponent: e_ab = ea + eb - 2*BIAS, BIAS = 2^(EXP_W-1)-1, signed EXP_W+2 bits. Overflow: e_ab > BIAS. Underflow: e_ab < 1-BIAS.
- sign_ab = sa^sb; effective c sign sc_e = sc^sub_mode; c_e = op_c with sign replaced by sc_e.
- Strict priority, first match wins:
  1. NaN: any NaN -> first NaN in order a, b, c, payload unchanged.
  2. Invalid: (inf*0) or (product inf, c inf, sign_ab ≠ sc_e) -> canonical QNaN {0, all-1, 1, 0...} (0x7FC00000 at defaults).
  3. Overflow (no operand zero) -> {sign_ab, inf}.
  4. Underflow with nj_mode=1, no inf operand -> c_e.
  5. Zero: a or b zero -> c_e.
  6. Inf: product inf -> {sign_ab, inf}; else c inf -> c_e.
  7. Otherwise mask 0, result 0.
- Stage 1 registers classification flags, e_ab compare results, signs and operands; stage 2 registers priority mux result and mask.
- Sticky flags: on each output handshake (out_valid & out_ready), OR of enabled-lane case hits (invalid class: case 2; nan: case 1; etc.) into flags. flag_clr clears; if clr and a set occur in the same cycle, the new set wins (flag ends 1).

## Timing
- Latency 2 cycles from accepted input to out_valid, no stall.
- Stage k advances when it is empty or stage k+1 advances; stage 2 advances when out_ready or empty. in_ready = !s1_valid | s1_advance, combinational from out_ready.
- Throughput one beat per cycle with out_ready held high; bubbles collapse.
- Under stall (out_valid=1, out_ready=0): spec_mask, res_spec, out_valid held stable; no beat lost or duplicated.
- Reset: s1/s2 valid 0, out_valid 0, spec_mask 0, res_spec 0, flags 0; in_ready 0 while rst=1, 1 the cycle after. Reset mid-transfer discards in-flight beats without flag update.
- nj_mode, sub_mode, lane_en sampled with the input beat and carried down the pipe.

## Test plan
- Defaults, lane 0 a=0x3F800000, b=0x7F800000, c=0x7F800000, sub_mode=1 -> after 2 cycles mask[0]=1, res=0x7FC00000, flags invalid=1.
- a=0x7FC00001, b=0x7F800001, c=NaN -> res=0x7FC00001 (a wins); lane_en[0]=0 same data -> mask 0, res 0, no nan flag.
- a=0x7F000000, b=0x7F000000 (e_ab=254>127) -> res 0x7F800000, overflow flag; a=0x00800000, b=0x00800000, c=0x40000000, nj_mode=1 -> res 0x40000000; nj_mode=0 -> mask 0.
- a=0x00000000, b=0xBF800000, c=0x3F800000, sub_mode=1 -> res 0xBF800000.
- Stream 8 beats, out_ready toggling 1010...: outputs in order, held during stall, none lost; flag_clr coincident with new overflow -> overflow stays 1.
- Assert rst with both stages full -> next cycle out_valid=0, flags=0; LANES=2, EXP_W=5, MAN_W=10 build: half-precision 0x7C00*0x0000 -> 0x7E00.
